// File: rtl/life_if.sv
// life_if: control inputs and grid/LFSR status of life_engine.
// N must equal the engine's ROWS*COLS.
interface life_if #(parameter int N = 64);
    logic        rand_sw;
    logic        start_sw;
    logic        step;
    logic        load_seed;
    logic [63:0] seed;
    logic [N-1:0] grid_out;
    logic [63:0] lfsr_out;
    logic [15:0] gen_count;
    logic        running;
    logic        stable;
    modport master (
        output rand_sw, start_sw, step, load_seed, seed,
        input  grid_out, lfsr_out, gen_count, running, stable
    );
    modport slave (
        input  rand_sw, start_sw, step, load_seed, seed,
        output grid_out, lfsr_out, gen_count, running, stable
    );
endinterface

// File: rtl/life_engine.sv
// life_engine: Conway B3/S23 grid with LFSR random fill and timed free-run.
// Define LIFE_TORUS_EN to wrap neighbours across the grid edges.
module life_engine #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int GEN_DIV = 4
) (
    input logic   clk,
    input logic   reset,
    life_if.slave bus
);
    localparam int N = ROWS * COLS;
    localparam logic [15:0] TICK_MAX = 16'(GEN_DIV - 1);

    typedef enum logic [1:0] {IDLE, RAND, RUN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grid_q, grid_d, next_gen;
    logic [63:0]    lfsr_q, lfsr_d, lfsr_next;
    logic [15:0]    tick_q, tick_d, gen_q, gen_d;
    logic           stable_q, stable_d, do_gen;
    logic           pad [0:ROWS+1][0:COLS+1];

    // Grid framed by a one-cell border holding either wrapped cells or zeros.
    for (genvar r = 0; r < ROWS + 2; r++) begin : g_pr
        for (genvar c = 0; c < COLS + 2; c++) begin : g_pc
`ifdef LIFE_TORUS_EN
            assign pad[r][c] = grid_q[((r + ROWS - 1) % ROWS) * COLS + (c + COLS - 1) % COLS];
`else
            if (r > 0 && r <= ROWS && c > 0 && c <= COLS) begin : g_in
                assign pad[r][c] = grid_q[(r - 1) * COLS + c - 1];
            end else begin : g_out
                assign pad[r][c] = 1'b0;
            end
`endif
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            logic [3:0] cnt;
            assign cnt = 4'(pad[r][c])     + 4'(pad[r][c+1])   + 4'(pad[r][c+2]) +
                         4'(pad[r+1][c])   + 4'(pad[r+1][c+2]) +
                         4'(pad[r+2][c])   + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
            assign next_gen[r*COLS+c] = cnt == 4'd3 || (cnt == 4'd2 && grid_q[r*COLS+c]);
        end
    end

    assign lfsr_next = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    assign do_gen    = (state_q == IDLE && bus.step && !bus.load_seed) ||
                       (state_q == RUN && bus.start_sw && tick_q == TICK_MAX);

    always_comb begin
        state_d  = state_q;
        grid_d   = do_gen ? next_gen : grid_q;
        lfsr_d   = lfsr_q;
        tick_d   = tick_q;
        gen_d    = do_gen ? (gen_q == 16'hFFFF ? gen_q : gen_q + 16'd1) : gen_q;
        stable_d = do_gen ? next_gen == grid_q : stable_q;
        case (state_q)
            IDLE: begin
                state_d = bus.start_sw ? RUN : bus.rand_sw ? RAND : IDLE;
                tick_d  = '0;
                if (bus.load_seed) begin
                    lfsr_d = bus.seed == '0 ? 64'h1 : bus.seed;
                    gen_d  = '0;
                end
                if (!bus.start_sw && bus.rand_sw) begin
                    gen_d    = '0;
                    stable_d = 1'b0;
                end
            end
            RAND: begin
                state_d  = bus.rand_sw ? RAND : IDLE;
                lfsr_d   = lfsr_next;
                grid_d   = lfsr_next[N-1:0];
                stable_d = 1'b0;
            end
            RUN: begin
                state_d = bus.start_sw ? RUN : IDLE;
                tick_d  = !bus.start_sw || tick_q == TICK_MAX ? '0 : tick_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            lfsr_q   <= 64'h1;
            tick_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            lfsr_q   <= lfsr_d;
            tick_q   <= tick_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
        end
    end

    assign bus.grid_out  = grid_q;
    assign bus.lfsr_out  = lfsr_q;
    assign bus.gen_count = gen_q;
    assign bus.running   = state_q == RUN;
    assign bus.stable    = stable_q;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of a 5x5 and an 8x8 life_engine sharing clock and reset.
module tb_life_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    life_if #(.N(25)) b5 ();
    life_if #(.N(64)) b8 ();

    life_engine #(.ROWS(5), .COLS(5), .GEN_DIV(4)) u5 (.clk(clk), .reset(reset), .bus(b5));
    life_engine #(.ROWS(8), .COLS(8), .GEN_DIV(4)) u8 (.clk(clk), .reset(reset), .bus(b8));

    localparam logic [63:0] VBLINK = (64'd1 << 7)  | (64'd1 << 12) | (64'd1 << 17);
    localparam logic [63:0] HBLINK = (64'd1 << 11) | (64'd1 << 12) | (64'd1 << 13);
    localparam logic [63:0] BLOCK  = (64'd1 << 0)  | (64'd1 << 1)  | (64'd1 << 8)  | (64'd1 << 9);
    localparam logic [63:0] GLIDER = (64'd1 << 1)  | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] GLID20 = (64'd1 << 46) | (64'd1 << 55) | (64'd1 << 61) | (64'd1 << 62) | (64'd1 << 63);
    localparam logic [63:0] CORNER = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Seed whose first LFSR advance leaves pattern p in the low bits.
    function automatic logic [63:0] seed_for(input logic [63:0] p);
        logic [63:0] s;
        s = p >> 1;
        s[63] = p[0] ^ s[62] ^ s[60] ^ s[59];
        return s;
    endfunction

    task automatic fill5(input logic [63:0] p);
        b5.seed = seed_for(p);
        b5.load_seed = 1'b1;
        cyc(1);
        b5.load_seed = 1'b0;
        b5.rand_sw = 1'b1;
        cyc(1);
        b5.rand_sw = 1'b0;
        cyc(1);
    endtask

    task automatic fill8(input logic [63:0] p);
        b8.seed = seed_for(p);
        b8.load_seed = 1'b1;
        cyc(1);
        b8.load_seed = 1'b0;
        b8.rand_sw = 1'b1;
        cyc(1);
        b8.rand_sw = 1'b0;
        cyc(1);
    endtask

    initial begin
        {b5.rand_sw, b5.start_sw, b5.step, b5.load_seed} = '0;
        {b8.rand_sw, b8.start_sw, b8.step, b8.load_seed} = '0;
        b5.seed = '0;
        b8.seed = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_grid", b8.grid_out, 64'h0);
        check("rst_lfsr", b8.lfsr_out, 64'h1);
        check("rst_gen", 64'(b8.gen_count), 64'h0);
        check("rst_running", 64'(b8.running), 64'h0);
        check("rst_stable", 64'(b8.stable), 64'h0);
        check("rst_grid5", 64'(b5.grid_out), 64'h0);
        cyc(2);
        reset = 1'b0;

        b8.seed = 64'h0;
        b8.load_seed = 1'b1;
        cyc(1);
        b8.load_seed = 1'b0;
        check("seed0_guard", b8.lfsr_out, 64'h1);
        b8.rand_sw = 1'b1;
        cyc(1);
        b8.rand_sw = 1'b0;
        cyc(1);
        check("rand_lfsr", b8.lfsr_out, 64'h2);
        check("rand_grid", b8.grid_out, 64'h2);
        check("rand_gen", 64'(b8.gen_count), 64'h0);
        check("rand_running", 64'(b8.running), 64'h0);

        fill5(VBLINK);
        check("fill_vblink", 64'(b5.grid_out), VBLINK);
        b5.step = 1'b1;
        cyc(1);
        b5.step = 1'b0;
        check("blink_h", 64'(b5.grid_out), HBLINK);
        check("blink_gen1", 64'(b5.gen_count), 64'd1);
        check("blink_stable", 64'(b5.stable), 64'h0);
        b5.step = 1'b1;
        cyc(1);
        b5.step = 1'b0;
        check("blink_v", 64'(b5.grid_out), VBLINK);
        check("blink_gen2", 64'(b5.gen_count), 64'd2);

        b5.seed = 64'hABCD;
        b5.load_seed = 1'b1;
        b5.step = 1'b1;
        cyc(1);
        {b5.load_seed, b5.step} = '0;
        check("ldstep_grid", 64'(b5.grid_out), VBLINK);
        check("ldstep_gen", 64'(b5.gen_count), 64'h0);
        check("ldstep_lfsr", b5.lfsr_out, 64'hABCD);

        fill8(BLOCK);
        check("fill_block", b8.grid_out, BLOCK);
        b8.start_sw = 1'b1;
        cyc(1);
        check("run_enter", 64'(b8.running), 64'h1);
        b8.step = 1'b1;
        cyc(3);
        b8.step = 1'b0;
        check("run_gen_pre", 64'(b8.gen_count), 64'h0);
        cyc(1);
        check("run_gen1", 64'(b8.gen_count), 64'd1);
        check("run_block", b8.grid_out, BLOCK);
        check("run_stable", 64'(b8.stable), 64'h1);
        b8.start_sw = 1'b0;
        cyc(1);
        check("run_exit", 64'(b8.running), 64'h0);
        check("run_exit_gen", 64'(b8.gen_count), 64'd1);

        fill8(GLIDER);
        check("fill_glider", b8.grid_out, GLIDER);
        check("fill_gen_clr", 64'(b8.gen_count), 64'h0);
        b8.step = 1'b1;
        cyc(20);
        check("glider_g20", b8.grid_out, GLID20);
        cyc(12);
        b8.step = 1'b0;
        check("glider_gen32", 64'(b8.gen_count), 64'd32);
`ifdef LIFE_TORUS_EN
        check("glider_g32", b8.grid_out, GLIDER);
        check("glider_stable", 64'(b8.stable), 64'h0);
`else
        check("glider_g32", b8.grid_out, CORNER);
        check("glider_stable", 64'(b8.stable), 64'h1);
`endif

        b8.start_sw = 1'b1;
        cyc(2);
        check("mid_run", 64'(b8.running), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_grid", b8.grid_out, 64'h0);
        check("arst_lfsr", b8.lfsr_out, 64'h1);
        check("arst_gen", 64'(b8.gen_count), 64'h0);
        check("arst_running", 64'(b8.running), 64'h0);
        check("arst_stable", 64'(b8.stable), 64'h0);
        cyc(1);
        check("arst_hold", 64'(b8.running), 64'h0);
        reset = 1'b0;
        cyc(1);
        check("rerun_enter", 64'(b8.running), 64'h1);
        cyc(3);
        check("rerun_pre", 64'(b8.gen_count), 64'h0);
        cyc(1);
        check("rerun_gen1", 64'(b8.gen_count), 64'd1);
        check("rerun_stable", 64'(b8.stable), 64'h1);

        b8.start_sw = 1'b0;
        cyc(1);
        b8.rand_sw = 1'b1;
        b8.start_sw = 1'b1;
        cyc(1);
        check("prio_run", 64'(b8.running), 64'h1);
        cyc(1);
        check("prio_lfsr", b8.lfsr_out, 64'h1);
        {b8.rand_sw, b8.start_sw} = '0;
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
